// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
//   Shared types and constants for the fetch-stage PC sequencing controller.
//   - state_t  : controller states (IDLE, FETCH, HALTED)
//   - rclass_t : redirect class; the numeric order equals redirect priority,
//                so a plain magnitude compare selects the stronger redirect.
//   - DEF_*    : default reset / exception vectors.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        RC_NONE = 3'd0,
        RC_JMP  = 3'd1,
        RC_BR   = 3'd2,
        RC_ERET = 3'd3,
        RC_EXC  = 3'd4
    } rclass_t;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/fetch_redirect_sel.sv
// fetch_redirect_sel
//   Combinational redirect arbiter. Classifies the live redirect inputs
//   (exc > eret > branch > jump) and picks the stronger of the live redirect
//   and the buffered pending redirect; a live redirect wins a tie.
//   Ports:
//     i_exc, i_eret            exception / return requests
//     i_br_taken, i_br_target  taken branch and its target
//     i_jmp_valid, i_jmp_target jump and its target
//     i_epc                    current exception PC (eret target)
//     i_pend_valid/class/target buffered redirect entry
//     o_live_wins              a live redirect exists and beats the pending one
//     o_win_class/o_win_target winning redirect (RC_NONE if none at all)
module fetch_redirect_sel
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned               WORD_SIZE  = 32,
    parameter logic [WORD_SIZE-1:0]      EXC_VECTOR = WORD_SIZE'(DEF_EXC_VECTOR)
) (
    input  logic                 i_exc,
    input  logic                 i_eret,
    input  logic                 i_br_taken,
    input  logic [WORD_SIZE-1:0] i_br_target,
    input  logic                 i_jmp_valid,
    input  logic [WORD_SIZE-1:0] i_jmp_target,
    input  logic [WORD_SIZE-1:0] i_epc,
    input  logic                 i_pend_valid,
    input  logic [2:0]           i_pend_class,
    input  logic [WORD_SIZE-1:0] i_pend_target,
    output logic                 o_live_wins,
    output logic [2:0]           o_win_class,
    output logic [WORD_SIZE-1:0] o_win_target
);

    rclass_t              w_live_class;
    logic [WORD_SIZE-1:0] w_live_target;
    rclass_t              w_pend_class;

    always_comb begin
        w_live_class  = RC_NONE;
        w_live_target = '0;
        if (i_exc) begin
            w_live_class  = RC_EXC;
            w_live_target = EXC_VECTOR;
        end else if (i_eret) begin
            w_live_class  = RC_ERET;
            w_live_target = i_epc;
        end else if (i_br_taken) begin
            w_live_class  = RC_BR;
            w_live_target = i_br_target;
        end else if (i_jmp_valid) begin
            w_live_class  = RC_JMP;
            w_live_target = i_jmp_target;
        end
    end

    always_comb begin
        w_pend_class = i_pend_valid ? rclass_t'(i_pend_class) : RC_NONE;
        o_live_wins  = (w_live_class != RC_NONE) && (w_live_class >= w_pend_class);
        o_win_class  = o_live_wins ? w_live_class  : w_pend_class;
        o_win_target = o_live_wins ? w_live_target : i_pend_target;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Sequencing controller for the PC register. Every cycle it chooses the
//   value the PC loads (pc_next) and whether it holds (pc_halt), based on the
//   instruction-memory handshake, hazard stall, redirects and halt request.
//   One redirect arriving while the PC cannot advance is buffered; the
//   exception PC is kept in epc.
//   Ports:
//     clk, rst_n               clock, asynchronous active-low reset
//     pc_cur                   current PC register value
//     pc_next, pc_halt         PC register load value / hold
//     imem_req, imem_ready     fetch request for pc_cur / instruction available
//     fetch_valid              instruction at pc_cur is consumed
//     stall                    hazard stall
//     br_taken/br_target, jmp_valid/jmp_target, exc, eret  redirects
//     halt_req                 stop fetching until reset
//     epc                      exception PC register
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned          WORD_SIZE    = 32,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = WORD_SIZE'(DEF_RESET_VECTOR),
    parameter logic [WORD_SIZE-1:0] EXC_VECTOR   = WORD_SIZE'(DEF_EXC_VECTOR)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WORD_SIZE-1:0] pc_cur,
    output logic [WORD_SIZE-1:0] pc_next,
    output logic                 pc_halt,
    output logic                 imem_req,
    input  logic                 imem_ready,
    output logic                 fetch_valid,
    input  logic                 stall,
    input  logic                 br_taken,
    input  logic [WORD_SIZE-1:0] br_target,
    input  logic                 jmp_valid,
    input  logic [WORD_SIZE-1:0] jmp_target,
    input  logic                 exc,
    input  logic                 eret,
    input  logic                 halt_req,
    output logic [WORD_SIZE-1:0] epc
);

    state_t               r_state;
    logic                 r_pend_valid;
    rclass_t              r_pend_class;
    logic [WORD_SIZE-1:0] r_pend_target;
    logic [WORD_SIZE-1:0] r_epc;

    logic                 w_live_wins;
    logic [2:0]           w_win_class;
    logic [WORD_SIZE-1:0] w_win_target;
    logic                 w_advance;

    // The same arbiter result serves both paths: on advance it is the
    // redirect to apply; on a blocked cycle it is exactly what the pending
    // entry should hold (live if it wins, otherwise the existing entry).
    fetch_redirect_sel #(
        .WORD_SIZE  (WORD_SIZE),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_sel (
        .i_exc         (exc),
        .i_eret        (eret),
        .i_br_taken    (br_taken),
        .i_br_target   (br_target),
        .i_jmp_valid   (jmp_valid),
        .i_jmp_target  (jmp_target),
        .i_epc         (r_epc),
        .i_pend_valid  (r_pend_valid),
        .i_pend_class  (r_pend_class),
        .i_pend_target (r_pend_target),
        .o_live_wins   (w_live_wins),
        .o_win_class   (w_win_class),
        .o_win_target  (w_win_target)
    );

    assign w_advance = (r_state == FETCH) && imem_ready && !stall && !halt_req;
    assign epc       = r_epc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pend_valid  <= 1'b0;
            r_pend_class  <= RC_NONE;
            r_pend_target <= '0;
            r_epc         <= '0;
        end else begin
            case (r_state)
                IDLE: r_state <= FETCH;
                FETCH: begin
                    if (halt_req) begin
                        r_state      <= HALTED;
                        r_pend_valid <= 1'b0;
                        r_pend_class <= RC_NONE;
                    end else begin
                        if (w_advance) begin
                            r_pend_valid <= 1'b0;
                            r_pend_class <= RC_NONE;
                        end else if (w_live_wins) begin
                            r_pend_valid  <= 1'b1;
                            r_pend_class  <= rclass_t'(w_win_class);
                            r_pend_target <= w_win_target;
                        end
                        // exc is top priority, so it is always either
                        // applied or latched here.
                        if (exc) begin
                            r_epc <= pc_cur;
                        end
                    end
                end
                HALTED: r_state <= HALTED;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        pc_next     = pc_cur;
        pc_halt     = 1'b1;
        imem_req    = 1'b0;
        fetch_valid = 1'b0;
        case (r_state)
            IDLE: begin
                pc_next = RESET_VECTOR;
                pc_halt = 1'b0;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (w_advance) begin
                    pc_halt     = 1'b0;
                    fetch_valid = !r_pend_valid;
                    pc_next     = (rclass_t'(w_win_class) != RC_NONE) ? w_win_target
                                                                      : pc_cur + WORD_SIZE'(4);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] EV = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_cur, pc_next, br_target, jmp_target, epc;
    logic        pc_halt, imem_req, imem_ready, fetch_valid, stall;
    logic        br_taken, jmp_valid, exc, eret, halt_req;

    always #5 clk = ~clk;

    // PC register driven by the controller
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pc_cur <= RV;
        else if (!pc_halt) pc_cur <= pc_next;
    end

    fetch_ctrl #(
        .WORD_SIZE    (32),
        .RESET_VECTOR (RV),
        .EXC_VECTOR   (EV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_cur      (pc_cur),
        .pc_next     (pc_next),
        .pc_halt     (pc_halt),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .fetch_valid (fetch_valid),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmp_valid   (jmp_valid),
        .jmp_target  (jmp_target),
        .exc         (exc),
        .eret        (eret),
        .halt_req    (halt_req),
        .epc         (epc)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0 = before first fetch, 1 = fetching, 2 = halted.
    // Pending redirect stored as a priority number (0 none .. 4 exception).
    int          m_mode, n_mode;
    bit          m_pv, n_pv;
    int          m_pprio, n_pprio;
    logic [31:0] m_ptgt, n_ptgt, m_epc, n_epc, m_pc;
    logic [31:0] e_pc_next;
    logic        e_halt, e_req, e_fv;

    task automatic model_reset();
        m_mode = 0; m_pv = 0; m_pprio = 0; m_ptgt = '0; m_epc = '0; m_pc = RV;
    endtask

    task automatic model_eval();
        int          lp, pp;
        logic [31:0] lt;
        n_mode = m_mode; n_pv = m_pv; n_pprio = m_pprio; n_ptgt = m_ptgt; n_epc = m_epc;
        e_req = 0; e_fv = 0; e_halt = 1; e_pc_next = m_pc;
        if (m_mode == 0) begin
            e_pc_next = RV; e_halt = 0; n_mode = 1;
        end else if (m_mode == 1) begin
            e_req = 1;
            if (halt_req) begin
                n_mode = 2; n_pv = 0; n_pprio = 0;
            end else begin
                lp = 0; lt = '0;
                if (exc)            begin lp = 4; lt = EV;         end
                else if (eret)      begin lp = 3; lt = m_epc;      end
                else if (br_taken)  begin lp = 2; lt = br_target;  end
                else if (jmp_valid) begin lp = 1; lt = jmp_target; end
                pp = m_pv ? m_pprio : 0;
                if (imem_ready && !stall) begin
                    e_halt = 0;
                    e_fv   = !m_pv;
                    if (lp > 0 && lp >= pp) e_pc_next = lt;
                    else if (pp > 0)        e_pc_next = m_ptgt;
                    else                    e_pc_next = m_pc + 32'd4;
                    n_pv = 0; n_pprio = 0;
                end else if (lp > 0 && lp >= pp) begin
                    n_pv = 1; n_pprio = lp; n_ptgt = lt;
                end
                if (lp == 4) n_epc = m_pc;
            end
        end
    endtask

    task automatic model_commit();
        if (!e_halt) m_pc = e_pc_next;
        m_mode = n_mode; m_pv = n_pv; m_pprio = n_pprio; m_ptgt = n_ptgt; m_epc = n_epc;
    endtask

    task automatic clear_inputs();
        imem_ready = 1; stall = 0; br_taken = 0; br_target = '0; jmp_valid = 0;
        jmp_target = '0; exc = 0; eret = 0; halt_req = 0;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic adv();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        checks++; if (pc_next !== RV) begin failures++; $display("FAIL reset_pc_next: got %h expected %h", pc_next, RV); end
        checks++; if (pc_halt !== 1'b0) begin failures++; $display("FAIL reset_pc_halt: got %b expected 0", pc_halt); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req: got %b expected 0", imem_req); end
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_fetch_valid: got %b expected 0", fetch_valid); end
        checks++; if (epc !== 32'h0) begin failures++; $display("FAIL reset_epc: got %h expected 0", epc); end
        adv();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (pc_cur !== 32'(i * 4)) begin failures++; $display("FAIL seq_pc_cur[%0d]: got %h expected %h", i, pc_cur, 32'(i * 4)); end
            checks++; if (fetch_valid !== 1'b1) begin failures++; $display("FAIL seq_fetch_valid[%0d]: got %b expected 1", i, fetch_valid); end
            adv();
        end
    endtask

    task automatic test_ready_branch();
        logic [31:0] held;
        held = m_pc;
        for (int i = 0; i < 3; i++) begin
            imem_ready = 0;
            br_taken   = (i == 0);
            br_target  = 32'h100;
            settle();
            checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL nready_fetch_valid[%0d]: got %b expected 0", i, fetch_valid); end
            checks++; if (pc_halt !== 1'b1) begin failures++; $display("FAIL nready_pc_halt[%0d]: got %b expected 1", i, pc_halt); end
            adv();
            checks++; if (pc_cur !== held) begin failures++; $display("FAIL nready_pc_held[%0d]: got %h expected %h", i, pc_cur, held); end
        end
        clear_inputs();
        settle();
        adv();
        checks++; if (pc_cur !== 32'h100) begin failures++; $display("FAIL pending_br_applied: got %h expected 100", pc_cur); end
    endtask

    task automatic test_exc_eret();
        clear_inputs();
        jmp_valid = 1; jmp_target = 32'h20;
        settle(); adv();
        clear_inputs();
        exc = 1; jmp_valid = 1; jmp_target = 32'h40;
        settle();
        checks++; if (pc_next !== EV) begin failures++; $display("FAIL exc_pc_next: got %h expected %h", pc_next, EV); end
        adv();
        checks++; if (pc_cur !== EV) begin failures++; $display("FAIL exc_pc_cur: got %h expected %h", pc_cur, EV); end
        checks++; if (epc !== 32'h20) begin failures++; $display("FAIL exc_epc: got %h expected 20", epc); end
        clear_inputs();
        settle(); adv();
        eret = 1;
        settle(); adv();
        checks++; if (pc_cur !== 32'h20) begin failures++; $display("FAIL eret_pc_cur: got %h expected 20", pc_cur); end
        clear_inputs();
    endtask

    task automatic test_pending_priority();
        clear_inputs();
        stall = 1; jmp_valid = 1; jmp_target = 32'h40;
        settle(); adv();
        jmp_valid = 0; br_taken = 1; br_target = 32'h200;
        settle(); adv();
        clear_inputs();
        settle();
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL pend_squash: got %b expected 0", fetch_valid); end
        adv();
        checks++; if (pc_cur !== 32'h200) begin failures++; $display("FAIL pend_br_over_jmp: got %h expected 200", pc_cur); end
        stall = 1; br_taken = 1; br_target = 32'h300;
        settle(); adv();
        br_taken = 0; jmp_valid = 1; jmp_target = 32'h44;
        settle(); adv();
        clear_inputs();
        settle(); adv();
        checks++; if (pc_cur !== 32'h300) begin failures++; $display("FAIL pend_br_kept: got %h expected 300", pc_cur); end
    endtask

    task automatic test_halt();
        clear_inputs();
        jmp_valid = 1; jmp_target = 32'h10;
        settle(); adv();
        clear_inputs();
        halt_req = 1; br_taken = 1; br_target = 32'h500;
        settle();
        checks++; if (pc_halt !== 1'b1) begin failures++; $display("FAIL halt_req_pc_halt: got %b expected 1", pc_halt); end
        adv();
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            exc = (i % 2 == 0);
            settle();
            checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL halted_imem_req[%0d]: got %b expected 0", i, imem_req); end
            checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL halted_fetch_valid[%0d]: got %b expected 0", i, fetch_valid); end
            adv();
            checks++; if (pc_cur !== 32'h10) begin failures++; $display("FAIL halted_pc[%0d]: got %h expected 10", i, pc_cur); end
            checks++; if (epc !== m_epc) begin failures++; $display("FAIL halted_epc[%0d]: got %h expected %h", i, epc, m_epc); end
        end
    endtask

    task automatic test_reset_midstall();
        do_reset();
        for (int i = 0; i < 4; i++) begin settle(); adv(); end
        stall = 1; exc = 1;
        settle(); adv();
        checks++; if (epc !== 32'hC) begin failures++; $display("FAIL midstall_epc_set: got %h expected c", epc); end
        exc = 0;
        settle(); adv();
        #2 rst_n = 0;
        model_reset();
        #1;
        checks++; if (epc !== 32'h0) begin failures++; $display("FAIL midstall_epc_cleared: got %h expected 0", epc); end
        checks++; if (pc_cur !== RV) begin failures++; $display("FAIL midstall_pc_reset: got %h expected %h", pc_cur, RV); end
        @(posedge clk);
        #1 rst_n = 1;
        clear_inputs();
        settle(); adv();
        settle();
        checks++; if (fetch_valid !== 1'b1) begin failures++; $display("FAIL midstall_no_pending: got %b expected 1", fetch_valid); end
        checks++; if (pc_next !== 32'h4) begin failures++; $display("FAIL midstall_resume_next: got %h expected 4", pc_next); end
        adv();
    endtask

    task automatic test_random();
        int halted_cycles;
        do_reset();
        halted_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            imem_ready = ($urandom_range(0, 3) != 0);
            stall      = ($urandom_range(0, 3) == 0);
            br_taken   = ($urandom_range(0, 6) == 0);
            jmp_valid  = ($urandom_range(0, 6) == 0);
            exc        = ($urandom_range(0, 19) == 0);
            eret       = ($urandom_range(0, 11) == 0);
            halt_req   = ($urandom_range(0, 199) == 0);
            br_target  = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            jmp_target = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            settle();
            checks++; if (pc_cur !== m_pc) begin failures++; $display("FAIL rnd_pc_cur[%0d]: got %h expected %h", i, pc_cur, m_pc); end
            checks++; if (pc_next !== e_pc_next) begin failures++; $display("FAIL rnd_pc_next[%0d]: got %h expected %h", i, pc_next, e_pc_next); end
            checks++; if (pc_halt !== e_halt) begin failures++; $display("FAIL rnd_pc_halt[%0d]: got %b expected %b", i, pc_halt, e_halt); end
            checks++; if (imem_req !== e_req) begin failures++; $display("FAIL rnd_imem_req[%0d]: got %b expected %b", i, imem_req, e_req); end
            checks++; if (epc !== m_epc) begin failures++; $display("FAIL rnd_epc[%0d]: got %h expected %h", i, epc, m_epc); end
            if (!(halt_req && m_mode == 1)) begin
                checks++; if (fetch_valid !== e_fv) begin failures++; $display("FAIL rnd_fetch_valid[%0d]: got %b expected %b", i, fetch_valid, e_fv); end
            end
            adv();
            if (m_mode == 2) halted_cycles++;
            if (halted_cycles > 6) begin
                do_reset();
                halted_cycles = 0;
            end
        end
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        model_reset();
        test_reset();
        test_sequential();
        test_ready_branch();
        test_exc_eret();
        test_pending_priority();
        test_halt();
        test_reset_midstall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
